// File: rtl/serial_adder_4bit.sv
// serial_adder_4bit
//
// Bit-serial ripple adder. Computes {Cout, Sum} = A + B + Cin over WIDTH clocks, LSB first,
// using a single full-adder cell and a carry flop. A start/busy/done handshake lets it sit
// behind a register file or control FSM.
//
// Parameters
//   WIDTH  operand/result width in bits (legal 2..16)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   A, B   in   operands, captured when start is accepted
//   Cin    in   carry-in, captured when start is accepted
//   busy   out  high while bits are being shifted through the adder cell
//   done   out  one-cycle pulse, Sum/Cout valid
//   Sum    out  result, held until the next operation completes
//   Cout   out  carry out of the MSB, held like Sum
//   Ovf    out  two's-complement overflow (only when SERIAL_ADD_OVF_EN is defined)
//
// Build option
//   SERIAL_ADD_OVF_EN  adds the Ovf output and its register.

module serial_adder_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_sum_bit;
    logic             w_carry_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // Single full-adder cell operating on the current LSBs.
    assign w_sum_bit    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_next = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last       = (r_cnt == CW'(WIDTH - 1));
    // Sum bits enter at the MSB so after WIDTH shifts bit 0 has reached position 0.
    assign w_res_next   = {w_sum_bit, r_res[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StShift;
            StShift: if (w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            StShift: busy = 1'b1;
            StDone:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: operand shift registers, carry, bit counter and held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (r_state == StIdle) begin
            if (start) begin
                r_a     <= A;
                r_b     <= B;
                r_carry <= Cin;
                r_cnt   <= '0;
            end
        end else if (r_state == StShift) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_carry_next;
            r_res   <= w_res_next;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_carry_next;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // On the last bit r_carry is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == StShift && w_last) begin
            r_ovf <= r_carry ^ w_carry_next;
        end
    end

    assign Ovf = r_ovf;
`endif

    assign Sum  = r_sum;
    assign Cout = r_cout;

endmodule

// File: tb/tb_serial_adder_4bit.sv
module tb_serial_adder_4bit;

    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_adder_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .Cin   (cin),
        .busy  (busy),
        .done  (done),
        .Sum   (sum),
        .Cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .Ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start high for one edge (DUT must be idle).
    task automatic start_op(input int a, input int b, input int c);
        a_in  = W'(a);
        b_in  = W'(b);
        cin   = c[0];
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called just after the accepting edge. Walks the WIDTH shift cycles, checks the done
    // pulse timing and result against plain integer addition, then returns to idle.
    // inject > 0: raise start with different operands before that shift edge.
    task automatic finish_op(input string tag, input int a, input int b, input int c,
                             input int inject);
        int          full;
        logic [31:0] held_sum;
        logic [31:0] held_cout;
        full      = a + b + c;
        held_sum  = 32'(sum);
        held_cout = 32'(cout);
        check({tag, ":busy0"}, 32'(busy), 32'd1);
        check({tag, ":done0"}, 32'(done), 32'd0);
        for (int i = 1; i <= W; i++) begin
            if (i == inject) begin
                a_in  = W'(7);
                b_in  = W'(1);
                start = 1'b1;
            end
            step();
            start = 1'b0;
            if (i < W) begin
                check({tag, ":busy_mid"}, 32'(busy), 32'd1);
                check({tag, ":done_mid"}, 32'(done), 32'd0);
                check({tag, ":sum_hold"}, 32'(sum), held_sum);
                check({tag, ":cout_hold"}, 32'(cout), held_cout);
            end else begin
                check({tag, ":done"}, 32'(done), 32'd1);
                check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
                check({tag, ":sum"}, 32'(sum), 32'(full & MAXV));
                check({tag, ":cout"}, 32'(cout), 32'((full >> W) & 1));
`ifdef SERIAL_ADD_OVF_EN
                begin
                    int low_mask;
                    int c_msb;
                    low_mask = (1 << (W - 1)) - 1;
                    c_msb = (((a & low_mask) + (b & low_mask) + c) >> (W - 1)) & 1;
                    check({tag, ":ovf"}, 32'(ovf), 32'(c_msb ^ ((full >> W) & 1)));
                end
`endif
            end
        end
        step();
        check({tag, ":done_end"}, 32'(done), 32'd0);
        check({tag, ":busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ra;
        int rb;
        int rc;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        step();
        step();
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:sum", 32'(sum), 32'd0);
        check("reset:cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle:busy", 32'(busy), 32'd0);

        // T1
        start_op(5, 3, 0);
        finish_op("t1", 5, 3, 0, 0);

        // T2
        start_op(12, 6, 1);
        finish_op("t2a", 12, 6, 1, 0);
        start_op(15, 15, 1);
        finish_op("t2b", 15, 15, 1, 0);

        // T3: start held high, operands changed right after capture
        a_in  = W'(9);
        b_in  = W'(5);
        cin   = 1'b0;
        start = 1'b1;
        step();
        a_in  = W'(2);
        b_in  = W'(4);
        start = 1'b1;
        finish_op("t3a", 9, 5, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        finish_op("t3b", 2, 4, 0, 0);

        // T4: request during SHIFT is dropped
        start_op(1, 1, 0);
        finish_op("t4", 1, 1, 0, 2);
        for (int i = 0; i < W + 2; i++) begin
            step();
            check("t4:no_second_done", 32'(done), 32'd0);
            check("t4:no_second_busy", 32'(busy), 32'd0);
        end

        // T5: reset mid-SHIFT
        start_op(10, 7, 1);
        step();
        rst_n = 1'b0;
        #1;
        check("t5:busy", 32'(busy), 32'd0);
        check("t5:done", 32'(done), 32'd0);
        check("t5:sum", 32'(sum), 32'd0);
        check("t5:cout", 32'(cout), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            step();
            check("t5:no_done", 32'(done), 32'd0);
        end
        start_op(3, 4, 0);
        finish_op("t5b", 3, 4, 0, 0);

        // Random operands
        for (int i = 0; i < 24; i++) begin
            ra = int'($urandom_range(0, MAXV));
            rb = int'($urandom_range(0, MAXV));
            rc = int'($urandom_range(0, 1));
            start_op(ra, rb, rc);
            finish_op("rand", ra, rb, rc, 0);
        end

        // T6: exhaustive sweep
        for (int x = 0; x <= MAXV; x++) begin
            for (int y = 0; y <= MAXV; y++) begin
                for (int z = 0; z < 2; z++) begin
                    start_op(x, y, z);
                    finish_op("sweep", x, y, z, 0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
